// File: rtl/db_link_arbiter_pkg.sv
// Shared constants for the de Bruijn router link stage: arbiter state
// encoding and the default link payload width.
package db_link_arbiter_pkg;

    localparam int LINK_DATA_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_BUSY0 = BUSY0,
        S_BUSY1 = BUSY1
    } arb_state_e;

endpackage

// File: rtl/db_link_arbiter_mux2.sv
// 1-bit 2:1 mux cell; s_i=1 selects b_i.
module db_link_arbiter_mux2 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);
    assign y_o = s_i ? b_i : a_i;
endmodule

// File: rtl/db_link_arbiter.sv
// Two-input round-robin arbiter for one de Bruijn output link. A granted port
// owns the link for a whole packet; beats land in a single output register.
module db_link_arbiter
    import db_link_arbiter_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_src_q, out_src_d;

    logic [DATA_W:0] in0_bus, in1_bus, mux_bus;
    logic            link_free, acc;

    assign in0_bus = {in0_last, in0_data};
    assign in1_bus = {in1_last, in1_data};

    // {last, data} select follows the registered owner, never the request lines
    for (genvar g = 0; g <= DATA_W; g++) begin : g_mux
        db_link_arbiter_mux2 u_mux (
            .a_i (in0_bus[g]),
            .b_i (in1_bus[g]),
            .s_i (sel),
            .y_o (mux_bus[g])
        );
    end

    assign sel       = (state_q == S_BUSY1);
    assign busy      = (state_q != S_IDLE);
    assign link_free = ~out_valid_q | out_ready;
    assign in0_ready = (state_q == S_BUSY0) & link_free;
    assign in1_ready = (state_q == S_BUSY1) & link_free;
    assign acc       = (in0_valid & in0_ready) | (in1_valid & in1_ready);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        case (state_q)
            S_IDLE: begin
                if (in0_valid && in1_valid) state_d = prio_q ? S_BUSY1 : S_BUSY0;
                else if (in0_valid)         state_d = S_BUSY0;
                else if (in1_valid)         state_d = S_BUSY1;
            end
            S_BUSY0, S_BUSY1: begin
                if (acc && mux_bus[DATA_W]) begin
                    state_d = S_IDLE;
                    prio_d  = ~sel;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_bus[DATA_W-1:0];
            out_last_d  = mux_bus[DATA_W];
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule
